// File: rtl/sme_feeder.sv
// Upstream feeder for the SME string-match engine: buffers one framed record,
// replays it as SME char strobes, then waits for and forwards the match result.
`timescale 1ns/1ps
module sme_feeder #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_kind,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  input  logic       sme_match,
  input  logic [4:0] sme_match_index,
  output logic       res_valid,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       busy,
  output logic       str_loaded,
  output logic       err_ovf,
  output logic       err_nostr,
  output logic       err_timeout
);

  localparam int LW = $clog2(STR_MAX + 1);
  localparam int AW = $clog2(STR_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DROP,
    S_WAIT
  } state_t;

  state_t        state;
  logic [7:0]    mem [STR_MAX];
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] lim;
  logic [TW-1:0] cnt;
  logic          kind;
  logic          accept;
  logic          kind_cur;
  logic          to_drop;

  assign in_ready = ~reset & ((state == S_IDLE) | (state == S_LOAD));
  assign accept   = in_valid & in_ready;
  assign busy     = (state != S_IDLE);
  assign kind_cur = (state == S_IDLE) ? in_kind : kind;
  assign lim      = kind ? LW'(PAT_MAX) : LW'(STR_MAX);
  // a pattern with no string behind it is swallowed instead of sent
  assign to_drop  = kind_cur & ~str_loaded;

  always_ff @(posedge clk) begin
    if (accept) begin
      if (state == S_IDLE) begin
        mem[0] <= in_data;
      end else if (len < lim) begin
        mem[len[AW-1:0]] <= in_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len         <= '0;
      idx         <= '0;
      cnt         <= '0;
      kind        <= 1'b0;
      chardata    <= 8'h00;
      isstring    <= 1'b0;
      ispattern   <= 1'b0;
      res_valid   <= 1'b0;
      res_match   <= 1'b0;
      res_index   <= 5'd0;
      str_loaded  <= 1'b0;
      err_ovf     <= 1'b0;
      err_nostr   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            kind <= in_kind;
            len  <= LW'(1);
            if (!in_last) begin
              state <= S_LOAD;
            end else if (to_drop) begin
              state     <= S_DROP;
              err_nostr <= 1'b1;
            end else begin
              // single-beat record: first char comes straight from the input
              state     <= S_SEND;
              chardata  <= in_data;
              isstring  <= ~in_kind;
              ispattern <= in_kind;
              idx       <= LW'(1);
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            if (len < lim) begin
              len <= len + LW'(1);
            end else begin
              err_ovf <= 1'b1;
            end
            if (in_last) begin
              if (to_drop) begin
                state     <= S_DROP;
                err_nostr <= 1'b1;
              end else begin
                state     <= S_SEND;
                chardata  <= mem[0];
                isstring  <= ~kind;
                ispattern <= kind;
                idx       <= LW'(1);
              end
            end
          end
        end
        S_SEND: begin
          if (idx < len) begin
            chardata <= mem[idx[AW-1:0]];
            idx      <= idx + LW'(1);
          end else begin
            chardata  <= 8'h00;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            idx       <= '0;
            if (kind) begin
              state <= S_WAIT;
              cnt   <= '0;
            end else begin
              state      <= S_IDLE;
              str_loaded <= 1'b1;
            end
          end
        end
        S_DROP: begin
          state <= S_IDLE;
        end
        S_WAIT: begin
          // a result arriving on the expiry cycle takes priority over the timeout
          if (sme_valid) begin
            res_valid <= 1'b1;
            res_match <= sme_match;
            res_index <= sme_match_index;
            state     <= S_IDLE;
          end else if (cnt == TW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt + TW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
